line_memory: RTL and testbench

LINE_MEMORY -- requirements
Module: line_memory

---
 rtl/line_memory_pkg.sv | 33 +++
 rtl/lm_delay_counter.sv | 32 +++
 rtl/line_memory.sv | 140 ++++++++++++++
 tb/tb_line_memory.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_memory_pkg.sv
// Shared types and constants for the line memory: FSM state encoding,
// default parameter values and a ceiling-log2 helper used to size the
// byte-offset field and the memory index.
package line_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } lm_state_t;

    localparam int LM_LINE_W_DEF  = 256;
    localparam int LM_DEPTH_DEF   = 512;
    localparam int LM_ADDR_W_DEF  = 32;
    localparam int LM_LATENCY_DEF = 10;
    localparam int LM_CNT_W_DEF   = 16;

    // The delay counter only ever holds LATENCY-1, and LATENCY <= 255.
    localparam int LM_DLY_W = 8;

    // Smallest r with 2**r >= value; used for the byte-offset width.
    function automatic int lm_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lm_delay_counter.sv
// Down-counter that times the access latency. Loaded with LATENCY-1 when a
// request is accepted, it counts down while enabled and reports done when
// it reaches zero.
module lm_delay_counter
    import line_memory_pkg::*;
#(
    parameter int DLY_W = LM_DLY_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DLY_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [DLY_W-1:0] cnt_q;

    // Load on acceptance, otherwise count down towards zero and stop there.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/line_memory.sv
// Line-organised memory model with a fixed access latency. One request is
// accepted at a time: the address, data and direction are captured, a delay
// counter runs for LATENCY cycles, then the access happens and a one-cycle
// ack is produced. Out-of-range line indices complete with err_o and never
// modify storage. Completed reads and writes are counted with saturation.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LINE_W  = LM_LINE_W_DEF,
    parameter int DEPTH   = LM_DEPTH_DEF,
    parameter int ADDR_W  = LM_ADDR_W_DEF,
    parameter int LATENCY = LM_LATENCY_DEF,
    parameter int CNT_W   = LM_CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  rd_count_o,
    output logic [CNT_W-1:0]  wr_count_o
);

    // Byte offset inside a line is dropped; the rest of the address is the line index.
    localparam int OFF_W  = lm_log2(LINE_W / 8);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? lm_log2(DEPTH) : 1;

    localparam logic [IDX_W-1:0]    DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [LM_DLY_W-1:0] DLY_LOAD  = LM_DLY_W'(LATENCY - 1);

    // Storage; deliberately left out of reset so contents survive it.
    logic [LINE_W-1:0] memory [0:DEPTH-1];

    lm_state_t         state_q;

    // Request captured at acceptance and held for the whole access.
    logic [IDX_W-1:0]  line_idx_p0;
    logic [LINE_W-1:0] wdata_p0;
    logic              wr_p0;

    logic              accept;
    logic              commit;
    logic              dly_done;
    logic              in_range;
    logic [MEM_AW-1:0] mem_idx;

    // The byte-offset bits never select anything.
    logic              unused_offset;

    assign unused_offset = ^addr_i[OFF_W-1:0];

    assign accept   = (state_q == IDLE) && enable_i;
    assign commit   = (state_q == WAIT) && dly_done;
    assign in_range = (line_idx_p0 < DEPTH_IDX);
    assign mem_idx  = line_idx_p0[MEM_AW-1:0];

    // Counter saturates at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    lm_delay_counter #(
        .DLY_W(LM_DLY_W)
    ) u_delay (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (accept),
        .load_val_i(DLY_LOAD),
        .en_i      (state_q == WAIT),
        .done_o    (dly_done)
    );

    // ---- stage p0: capture request fields on acceptance ----
    always_ff @(posedge clk_i) begin
        if (accept) begin
            line_idx_p0 <= addr_i[ADDR_W-1:OFF_W];
            wdata_p0    <= data_i;
            wr_p0       <= write_i;
        end
    end

    // Commit an in-range write on the edge that enters ACK; rst_i gates an aborted request.
    always_ff @(posedge clk_i) begin
        if (rst_i && commit && wr_p0 && in_range) begin
            memory[mem_idx] <= wdata_p0;
        end
    end

    // Request FSM with registered ack/err/busy, read data and access counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
            data_o     <= '0;
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= WAIT;
                        busy_o  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dly_done) begin
                        state_q <= ACK;
                        ack_o   <= 1'b1;
                        err_o   <= ~in_range;
                        if (wr_p0) begin
                            wr_count_o <= sat_inc(wr_count_o);
                        end else begin
                            rd_count_o <= sat_inc(rd_count_o);
                            data_o     <= in_range ? memory[mem_idx] : '0;
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: one instance with the default geometry and
// LATENCY=10, one small instance with LATENCY=1 and 4-bit counters.
module tb_line_memory;

    localparam int A_LW = 256, A_DEPTH = 512, A_AW = 32, A_LAT = 10, A_CW = 16;
    localparam int B_LW = 64,  B_DEPTH = 16,  B_AW = 16, B_LAT = 1,  B_CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic              rst_a, en_a, wr_a;
    logic [A_AW-1:0]   addr_a;
    logic [A_LW-1:0]   din_a, dout_a;
    logic              ack_a, busy_a, err_a;
    logic [A_CW-1:0]   rd_count_a, wr_count_a;

    // Instance B signals
    logic              rst_b, en_b, wr_b;
    logic [B_AW-1:0]   addr_b;
    logic [B_LW-1:0]   din_b, dout_b;
    logic              ack_b, busy_b, err_b;
    logic [B_CW-1:0]   rd_count_b, wr_count_b;

    line_memory #(
        .LINE_W(A_LW), .DEPTH(A_DEPTH), .ADDR_W(A_AW), .LATENCY(A_LAT), .CNT_W(A_CW)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .addr_i(addr_a), .data_i(din_a),
        .enable_i(en_a), .write_i(wr_a), .ack_o(ack_a), .data_o(dout_a),
        .busy_o(busy_a), .err_o(err_a), .rd_count_o(rd_count_a), .wr_count_o(wr_count_a)
    );

    line_memory #(
        .LINE_W(B_LW), .DEPTH(B_DEPTH), .ADDR_W(B_AW), .LATENCY(B_LAT), .CNT_W(B_CW)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .addr_i(addr_b), .data_i(din_b),
        .enable_i(en_b), .write_i(wr_b), .ack_o(ack_b), .data_o(dout_b),
        .busy_o(busy_b), .err_o(err_b), .rd_count_o(rd_count_b), .wr_count_o(wr_count_b)
    );

    function automatic logic [A_LW-1:0] rand256();
        logic [A_LW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic pulse_reset_a();
        @(negedge clk);
        en_a  = 1'b0;
        rst_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic pulse_reset_b();
        @(negedge clk);
        en_b  = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    // One request on instance A. Inputs are scrambled while the request is
    // in flight. Returns edges from acceptance to ack (-1 if none), busy
    // samples before ack, the ack-cycle outputs and the cycle after.
    task automatic req_a(input logic wr, input logic [A_AW-1:0] addr, input logic [A_LW-1:0] d,
                         output int lat, output int busy_pre, output logic err,
                         output logic [A_LW-1:0] rd, output logic busy_at_ack,
                         output logic ack_next, output logic busy_next);
        @(negedge clk);
        en_a = 1'b1; wr_a = wr; addr_a = addr; din_a = d;
        @(posedge clk); #1;
        en_a   = 1'($urandom_range(0, 1));
        wr_a   = 1'($urandom_range(0, 1));
        addr_a = 32'($urandom);
        din_a  = rand256();
        lat = -1; busy_pre = 0; err = 1'b0; rd = '0; busy_at_ack = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (ack_a === 1'b1) begin
                lat = k; err = err_a; rd = dout_a; busy_at_ack = busy_a;
                en_a = 1'b0;
                break;
            end
            if (busy_a === 1'b1) busy_pre++;
        end
        en_a = 1'b0;
        @(posedge clk); #1;
        ack_next  = ack_a;
        busy_next = busy_a;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ack_a !== 1'b0)        begin bad++; $display("FAIL reset_ack_a: got %b want 0", ack_a); end
        total++; if (busy_a !== 1'b0)       begin bad++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        total++; if (err_a !== 1'b0)        begin bad++; $display("FAIL reset_err_a: got %b want 0", err_a); end
        total++; if (dout_a !== '0)         begin bad++; $display("FAIL reset_data_a: got %h want 0", dout_a); end
        total++; if (rd_count_a !== '0)     begin bad++; $display("FAIL reset_rdcnt_a: got %0d want 0", rd_count_a); end
        total++; if (wr_count_a !== '0)     begin bad++; $display("FAIL reset_wrcnt_a: got %0d want 0", wr_count_a); end
        total++; if (ack_b !== 1'b0 || busy_b !== 1'b0 || err_b !== 1'b0)
                     begin bad++; $display("FAIL reset_ctl_b: got ack=%b busy=%b err=%b want 000", ack_b, busy_b, err_b); end
        total++; if (dout_b !== '0 || rd_count_b !== '0 || wr_count_b !== '0)
                     begin bad++; $display("FAIL reset_dat_b: got data=%h rd=%0d wr=%0d want 0", dout_b, rd_count_b, wr_count_b); end
        rst_a = 1'b1;
        rst_b = 1'b1;
    endtask

    task automatic test_read_latency();
        int lat, bp; logic e, ba, an, bn; logic [A_LW-1:0] rd, pat;
        pat = rand256();
        req_a(1'b1, 32'h20, pat, lat, bp, e, rd, ba, an, bn);
        total++; if (dut_a.memory[1] !== pat) begin bad++; $display("FAIL preload_line1: got %h want %h", dut_a.memory[1], pat); end
        total++; if (rd !== '0) begin bad++; $display("FAIL write_keeps_data_o: got %h want 0", rd); end
        req_a(1'b0, 32'h20, '0, lat, bp, e, rd, ba, an, bn);
        total++; if (lat !== A_LAT) begin bad++; $display("FAIL rd_latency: got %0d want %0d", lat, A_LAT); end
        total++; if (bp !== A_LAT)  begin bad++; $display("FAIL rd_busy_cycles: got %0d want %0d", bp, A_LAT); end
        total++; if (rd !== pat)    begin bad++; $display("FAIL rd_data: got %h want %h", rd, pat); end
        total++; if (e !== 1'b0)    begin bad++; $display("FAIL rd_err: got %b want 0", e); end
        total++; if (ba !== 1'b1)   begin bad++; $display("FAIL busy_in_ack: got %b want 1", ba); end
        total++; if (an !== 1'b0)   begin bad++; $display("FAIL ack_one_cycle: got %b want 0", an); end
        total++; if (bn !== 1'b0)   begin bad++; $display("FAIL busy_after_ack: got %b want 0", bn); end
        total++; if (dout_a !== pat) begin bad++; $display("FAIL data_o_hold: got %h want %h", dout_a, pat); end
    endtask

    task automatic test_write_read();
        int lat, bp; logic e, ba, an, bn; logic [A_LW-1:0] rd, pat;
        pat = {16{16'hECFA}};
        pulse_reset_a();
        req_a(1'b1, 32'h40, pat, lat, bp, e, rd, ba, an, bn);
        total++; if (lat !== A_LAT) begin bad++; $display("FAIL wr_latency: got %0d want %0d", lat, A_LAT); end
        req_a(1'b0, 32'h40, '0, lat, bp, e, rd, ba, an, bn);
        total++; if (rd !== pat) begin bad++; $display("FAIL wr_rd_data: got %h want %h", rd, pat); end
        total++; if (wr_count_a !== 16'd1) begin bad++; $display("FAIL wr_rd_wrcnt: got %0d want 1", wr_count_a); end
        total++; if (rd_count_a !== 16'd1) begin bad++; $display("FAIL wr_rd_rdcnt: got %0d want 1", rd_count_a); end
    endtask

    task automatic test_out_of_range();
        int lat, bp; logic e, ba, an, bn; logic [A_LW-1:0] rd;
        logic [A_LW-1:0] snap [0:7];
        int changed;
        pulse_reset_a();
        for (int i = 0; i < 8; i++) snap[i] = dut_a.memory[i];
        req_a(1'b1, 32'h4000, rand256(), lat, bp, e, rd, ba, an, bn);
        total++; if (lat !== A_LAT || e !== 1'b1) begin bad++; $display("FAIL oor_wr_ack_err: got lat=%0d err=%b want lat=%0d err=1", lat, e, A_LAT); end
        total++; if (wr_count_a !== 16'd1) begin bad++; $display("FAIL oor_wrcnt: got %0d want 1", wr_count_a); end
        changed = 0;
        for (int i = 0; i < 8; i++) if (dut_a.memory[i] !== snap[i]) changed++;
        total++; if (changed !== 0) begin bad++; $display("FAIL oor_no_line_changed: got %0d changed lines want 0", changed); end
        req_a(1'b0, 32'h4000, '0, lat, bp, e, rd, ba, an, bn);
        total++; if (rd !== '0 || e !== 1'b1) begin bad++; $display("FAIL oor_rd: got data=%h err=%b want 0 err=1", rd, e); end
        total++; if (rd_count_a !== 16'd1) begin bad++; $display("FAIL oor_rdcnt: got %0d want 1", rd_count_a); end
    endtask

    task automatic test_reset_mid_op();
        int lat, bp, acks; logic e, ba, an, bn; logic [A_LW-1:0] rd, old_v, new_v;
        old_v = rand256();
        new_v = ~old_v;
        req_a(1'b1, 32'h60, old_v, lat, bp, e, rd, ba, an, bn);
        @(negedge clk);
        en_a = 1'b1; wr_a = 1'b1; addr_a = 32'h60; din_a = new_v;
        @(posedge clk); #1;
        en_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        total++; if (ack_a !== 1'b0 || busy_a !== 1'b0 || err_a !== 1'b0)
                     begin bad++; $display("FAIL midrst_ctl: got ack=%b busy=%b err=%b want 000", ack_a, busy_a, err_a); end
        total++; if (rd_count_a !== '0 || wr_count_a !== '0)
                     begin bad++; $display("FAIL midrst_counts: got rd=%0d wr=%0d want 0 0", rd_count_a, wr_count_a); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        acks = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (ack_a === 1'b1 || busy_a === 1'b1) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL midrst_no_ack: got %0d active cycles want 0", acks); end
        total++; if (dut_a.memory[3] !== old_v) begin bad++; $display("FAIL midrst_line_kept: got %h want %h", dut_a.memory[3], old_v); end
        req_a(1'b0, 32'h60, '0, lat, bp, e, rd, ba, an, bn);
        total++; if (lat !== A_LAT || rd !== old_v) begin bad++; $display("FAIL midrst_next_req: got lat=%0d data=%h want lat=%0d data=%h", lat, rd, A_LAT, old_v); end
        total++; if (rd_count_a !== 16'd1 || wr_count_a !== 16'd0) begin bad++; $display("FAIL midrst_next_counts: got rd=%0d wr=%0d want 1 0", rd_count_a, wr_count_a); end
    endtask

    task automatic test_random();
        logic [A_LW-1:0] mem_m [0:7];
        bit              written [0:7];
        logic [A_LW-1:0] last_rd_m, d, rd, exp_d;
        int              rd_m, wr_m, line, lat, bp;
        logic            wr, oor, e, ba, an, bn;
        logic [A_AW-1:0] addr;
        pulse_reset_a();
        for (int i = 0; i < 8; i++) written[i] = 1'b0;
        last_rd_m = '0; rd_m = 0; wr_m = 0;
        for (int t = 0; t < 30; t++) begin
            line = (t == 0) ? 8 : int'($urandom_range(0, 8));
            oor  = (line == 8);
            if (oor) addr = 32'($urandom) | 32'h0000_4000;
            else     addr = 32'(line * 32 + int'($urandom_range(0, 31)));
            if (t == 0)                    wr = 1'b0;
            else if (!oor && !written[line]) wr = 1'b1;
            else                           wr = 1'($urandom_range(0, 1));
            d = rand256();
            req_a(wr, addr, d, lat, bp, e, rd, ba, an, bn);
            if (wr) begin
                wr_m++;
                if (!oor) begin mem_m[line] = d; written[line] = 1'b1; end
                exp_d = last_rd_m;
            end else begin
                rd_m++;
                exp_d = oor ? '0 : mem_m[line];
                last_rd_m = exp_d;
            end
            total++; if (lat !== A_LAT || e !== oor || rd !== exp_d)
                         begin bad++; $display("FAIL rand_txn%0d: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h", t, lat, e, rd, A_LAT, oor, exp_d); end
            total++; if (rd_count_a !== 16'(rd_m) || wr_count_a !== 16'(wr_m))
                         begin bad++; $display("FAIL rand_counts%0d: got rd=%0d wr=%0d want rd=%0d wr=%0d", t, rd_count_a, wr_count_a, rd_m, wr_m); end
        end
    endtask

    task automatic test_back_to_back();
        logic [B_LW-1:0] d;
        logic            exp_ack;
        int              acks;
        pulse_reset_b();
        d = {$urandom, $urandom};
        @(negedge clk);
        en_b = 1'b1; wr_b = 1'b1; addr_b = 16'h0010; din_b = d;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            exp_ack = ((k % 3) == 2);
            acks = (k + 1) / 3;
            total++; if (ack_b !== exp_ack) begin bad++; $display("FAIL b2b_wr_ack_edge%0d: got %b want %b", k, ack_b, exp_ack); end
            total++; if (wr_count_b !== 4'(acks)) begin bad++; $display("FAIL b2b_wrcnt_edge%0d: got %0d want %0d", k, wr_count_b, acks); end
        end
        @(negedge clk);
        wr_b = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            exp_ack = ((k % 3) == 2);
            acks = (k + 1) / 3;
            total++; if (ack_b !== exp_ack) begin bad++; $display("FAIL b2b_rd_ack_edge%0d: got %b want %b", k, ack_b, exp_ack); end
            total++; if (rd_count_b !== 4'(acks)) begin bad++; $display("FAIL b2b_rdcnt_edge%0d: got %0d want %0d", k, rd_count_b, acks); end
            if (exp_ack) begin
                total++; if (dout_b !== d) begin bad++; $display("FAIL b2b_rd_data_edge%0d: got %h want %h", k, dout_b, d); end
            end
        end
        @(negedge clk);
        en_b = 1'b0;
        total++; if (wr_count_b !== 4'd3) begin bad++; $display("FAIL b2b_wrcnt_final: got %0d want 3", wr_count_b); end
    endtask

    task automatic test_saturation();
        logic [B_LW-1:0] keep;
        int              acks, exp_cnt;
        keep = dut_b.memory[2];
        pulse_reset_b();
        total++; if (dut_b.memory[2] !== keep) begin bad++; $display("FAIL reset_keeps_memory: got %h want %h", dut_b.memory[2], keep); end
        @(negedge clk);
        en_b = 1'b1; wr_b = 1'b0; addr_b = 16'h0010;
        for (int k = 1; k <= 51; k++) begin
            @(posedge clk); #1;
            acks = (k + 1) / 3;
            exp_cnt = (acks > 15) ? 15 : acks;
            total++; if (rd_count_b !== 4'(exp_cnt)) begin bad++; $display("FAIL sat_rdcnt_edge%0d: got %0d want %0d", k, rd_count_b, exp_cnt); end
        end
        @(negedge clk);
        en_b = 1'b0;
        total++; if (rd_count_b !== 4'hF) begin bad++; $display("FAIL sat_final: got %h want f", rd_count_b); end
        total++; if (dout_b !== keep) begin bad++; $display("FAIL sat_rd_data: got %h want %h", dout_b, keep); end
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
        rst_b = 1'b0; en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
        test_reset();
        test_read_latency();
        test_write_read();
        test_out_of_range();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
